// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared widths, saturation bounds, FSM encoding and the
//                sat_round requant helper for convolution datapaths.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int SUM_BW   = 16;
    localparam int ACC_BW   = 24;
    localparam int DATA_BW  = 8;
    localparam int PASS_BW  = 4;
    localparam int SHIFT_BW = 5;

    localparam logic signed [DATA_BW-1:0] SAT_MAX = {1'b0, {(DATA_BW-1){1'b1}}};
    localparam logic signed [DATA_BW-1:0] SAT_MIN = {1'b1, {(DATA_BW-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    // Round-half-up shift, saturate, optional ReLU. A 64-bit intermediate keeps
    // the rounding constant exact for every shift up to 31.
    function automatic logic signed [DATA_BW-1:0] sat_round(
        input logic signed [ACC_BW-1:0]   fin,
        input logic        [SHIFT_BW-1:0] shift,
        input logic                       relu
    );
        logic signed [63:0]        w_ext;
        logic signed [63:0]        w_rnd;
        logic signed [63:0]        w_r;
        logic signed [DATA_BW-1:0] w_sat;
        w_ext = 64'(fin);
        w_rnd = (shift == '0) ? 64'sd0 : (64'sd1 <<< (shift - 1'b1));
        w_r   = (w_ext + w_rnd) >>> shift;
        if (w_r > 64'(SAT_MAX)) begin
            w_sat = SAT_MAX;
        end else if (w_r < 64'(SAT_MIN)) begin
            w_sat = SAT_MIN;
        end else begin
            w_sat = w_r[DATA_BW-1:0];
        end
        if (relu && (w_sat < 0)) begin
            w_sat = '0;
        end
        return w_sat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo2
//  Description : Two-entry valid/ready FIFO; push while full is only taken
//                when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_pop;
    logic             w_accept;

    assign o_empty  = (r_cnt == 2'd0);
    assign o_full   = (r_cnt == 2'd2);
    assign o_valid  = !o_empty;
    assign o_data   = r_mem[r_rptr];
    assign w_pop    = o_valid && i_ready;
    assign w_accept = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_requant.sv
`default_nettype none
// ============================================================================
//  Module      : psum_requant
//  Description : Multi-pass psum accumulation, bias add, requant to DATA_BW
//                and a 2-entry output buffer with sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_requant #(
    parameter int SUM_BW   = conv_pkg::SUM_BW,
    parameter int ACC_BW   = conv_pkg::ACC_BW,
    parameter int DATA_BW  = conv_pkg::DATA_BW,
    parameter int PASS_BW  = conv_pkg::PASS_BW,
    parameter int SHIFT_BW = conv_pkg::SHIFT_BW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_cfg_en,
    input  logic        [PASS_BW-1:0]  i_cfg_passes,
    input  logic        [SHIFT_BW-1:0] i_cfg_shift,
    input  logic                      i_cfg_relu,
    input  logic signed [ACC_BW-1:0]   i_cfg_bias,
    input  logic                      i_valid,
    input  logic signed [SUM_BW:0]     i_psum,
    output logic                      o_valid,
    output logic signed [DATA_BW-1:0]  o_data,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_overflow
);
    import conv_pkg::*;

    logic        [PASS_BW-1:0]  r_passes;
    logic        [SHIFT_BW-1:0] r_shift;
    logic                       r_relu;
    logic signed [ACC_BW-1:0]   r_bias;
    logic signed [ACC_BW-1:0]   r_acc;
    logic        [PASS_BW-1:0]  r_count;
    logic signed [ACC_BW-1:0]   r_fin;
    logic                       r_fin_v;
    logic        [SHIFT_BW-1:0] r_fin_shift;
    logic                       r_fin_relu;
    acc_state_t                 r_state;

    logic signed [ACC_BW-1:0]   w_psum_ext;
    logic signed [ACC_BW-1:0]   w_base;
    logic                       w_last;
    logic                       w_cfg_load;
    logic signed [DATA_BW-1:0]  w_res;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_drop;

    assign w_psum_ext = {{(ACC_BW-SUM_BW-1){i_psum[SUM_BW]}}, i_psum};
    assign w_base     = (r_count == '0) ? w_psum_ext : (r_acc + w_psum_ext);
    // passes of 0 or 1 make every beat a complete group
    assign w_last     = (r_passes <= PASS_BW'(1)) || (r_count == (r_passes - PASS_BW'(1)));
    assign w_cfg_load = i_cfg_en && !o_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_passes   <= PASS_BW'(1);
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_bias     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (w_cfg_load) begin
                r_passes   <= i_cfg_passes;
                r_shift    <= i_cfg_shift;
                r_relu     <= i_cfg_relu;
                r_bias     <= i_cfg_bias;
                o_overflow <= 1'b0;
            end
            if (w_drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Requant settings travel with fin so a config load on the completing
    // beat cannot alter the result already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_fin       <= '0;
            r_fin_v     <= 1'b0;
            r_fin_shift <= '0;
            r_fin_relu  <= 1'b0;
            r_state     <= ST_IDLE;
            o_busy      <= 1'b0;
        end else begin
            r_fin_v <= 1'b0;
            if (i_valid) begin
                r_acc <= w_base;
                if (w_last) begin
                    r_fin       <= w_base + r_bias;
                    r_fin_v     <= 1'b1;
                    r_fin_shift <= r_shift;
                    r_fin_relu  <= r_relu;
                    r_count     <= '0;
                end else begin
                    r_count <= r_count + PASS_BW'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && !w_last) begin
                        r_state <= ST_ACCUM;
                        o_busy  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (i_valid && w_last) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_res  = sat_round(r_fin, r_fin_shift, r_fin_relu);
    assign w_drop = r_fin_v && w_full && !(!w_empty && i_ready);

    stream_fifo2 #(
        .WIDTH (DATA_BW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_fin_v),
        .i_data  (w_res),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: doc/psum_requant.md
# psum_requant

Downstream stage of the systolic PE column: consumes the final partial sum leaving the last processing element, accumulates it across channel-group passes, adds bias, and rescales to DATA_BW. The output is an 8-bit activation: right-shifted with rounding, saturated, and optionally passed through ReLU. Results leave through a 2-entry valid/ready buffer toward the AXI-stream writer. The PE chain cannot stall, so buffer overflow is flagged, not back-pressured.

## Interface
- SUM_BW, 16, PE psum width; input is SUM_BW+1 bits signed
- ACC_BW, 24, accumulator width, signed
- DATA_BW, 8, output activation width, signed
- PASS_BW, 4, width of pass-count config
- SHIFT_BW, 5, width of shift config
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_cfg_en  in  1  load config registers this cycle
- i_cfg_passes  in  PASS_BW  number of psum beats per output; 0 treated as 1
- i_cfg_shift  in  SHIFT_BW  arithmetic right-shift amount
- i_cfg_relu  in  1  clamp negative results to 0
- i_cfg_bias  in  ACC_BW signed  bias added once per output
- i_valid  in  1  i_psum valid this cycle
- i_psum  in  SUM_BW+1 signed  psum from last PE
- o_valid  out  1  output beat valid
- o_data  out  DATA_BW signed  activation
- i_ready  in  1  downstream accepts beat
- o_busy  out  1  accumulation in progress (pass count ≠ 0)
- o_overflow  out  1  sticky: a result was dropped because the buffer was full

## Operation
- Config registers load on i_cfg_en only while o_busy=0; otherwise i_cfg_en is ignored.
- A config load clears o_overflow. New config applies from the next cycle.
- A beat arriving in the same cycle as i_cfg_en uses the old config.
- Accumulate stage:
  - Each i_valid beat sign-extends i_psum to ACC_BW and adds it to acc.
  - The first beat of a group loads acc with the psum itself; there is no separate clear.
  - A pass counter counts beats. On the beat that completes the group (count = passes−1), the stage registers fin = acc + psum + bias, asserts fin_v, and returns the counter to 0.
  - Accumulator arithmetic wraps modulo 2^ACC_BW; sizing ACC_BW is the integrator's duty.
- Requant stage, combinational on fin and written into the buffer one cycle after fin_v:
  - If shift>0: r = (fin + 2^(shift−1)) >>> shift, round half up. If shift=0: r = fin.
  - Saturate r to [−2^(DATA_BW−1), 2^(DATA_BW−1)−1].
  - If relu is set and the saturated value <0, the result is 0.
- Output buffer is a 2-entry FIFO, FIFO order:
  - o_valid = not empty; a beat transfers when o_valid && i_ready.
  - When full, push together with pop in the same cycle is accepted.
  - When full with no pop, the pushed result is dropped and o_overflow is set.
- FSM: IDLE (count=0) → ACCUM on a beat when passes>1; ACCUM → IDLE on the completing beat. With passes≤1, every beat completes a group and the FSM stays in IDLE.

## Timing
- Reset values: acc=0, count=0, fin_v=0, FIFO empty, o_valid=0, o_data=0, o_busy=0, o_overflow=0; config passes=1, shift=0, relu=0, bias=0.
- Latency: completing beat sampled at edge E0 → fin registered at E0 → FIFO written at E1 → o_valid=1 after E1. That is 2 cycles, with an empty buffer.
- Throughput: one beat per cycle accepted at all times; i_valid is never refused.
- o_data is stable while o_valid && !i_ready.
- o_busy goes high the cycle after the first beat of a multi-pass group, and low the cycle after the completing beat.
- Reset mid-accumulation discards the partial acc, fin and buffered data immediately (asynchronous).

## Structure
- Shared package conv_pkg: SUM_BW/ACC_BW/DATA_BW defaults, saturation bounds as localparams, and a sat_round function (shift, round, saturate, relu) reusable by other requant points.
- One sub-module: stream_fifo2, a parameterised-width 2-entry valid/ready FIFO with full/empty outputs.
- FSM, counter, accumulator and requant logic live in psum_requant.

## Test plan
- passes=1, shift=0, bias=0, relu=0; psum 5 → o_data=5, o_valid 2 cycles after the beat.
- passes=3, shift=4, bias=0; psums 100, 200, 307 on consecutive cycles → 607 → (607+8)>>>4 = 38. Check o_busy high between beats.
- Saturation/ReLU: passes=1, shift=0; psum 1000 → 127; psum −1000 → −128; same with relu=1 → 0; bias −10 with psum 4 → −6 (relu=0).
- Backpressure: i_ready=0, three single-pass results → two held in order, third dropped, o_overflow=1. Then i_ready=1 → the two drain. A config load clears o_overflow.
- Config during busy: i_cfg_en with passes=1 after the 1st of 3 beats is ignored, and the group still completes after 3 beats.
- Reset mid-group: deassert rst_n after 2 of 3 beats → all outputs 0. The next 3 beats (10, 20, 30, shift 0) → 60, with no stale sum.
